// File: rtl/stopwatch_pkg.sv
// Shared field widths, limits and the packed time type for the stopwatch datapath.
// The time_inc helper implements the csec/sec/min/hour cascade in one place.
package stopwatch_pkg;

    localparam int unsigned CSEC_W   = 7;
    localparam int unsigned SEC_W    = 6;
    localparam int unsigned MIN_W    = 6;
    localparam int unsigned HOUR_W   = 5;

    localparam int unsigned CSEC_MAX = 99;
    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [CSEC_W-1:0] csec;
    } time_t;

    function automatic time_t time_inc(input time_t t);
        time_t n;
        n = t;
        if (t.csec != CSEC_W'(CSEC_MAX)) begin
            n.csec = t.csec + 1'b1;
        end else begin
            n.csec = '0;
            if (t.sec != SEC_W'(SEC_MAX)) begin
                n.sec = t.sec + 1'b1;
            end else begin
                n.sec = '0;
                if (t.min != MIN_W'(MIN_MAX)) begin
                    n.min = t.min + 1'b1;
                end else begin
                    n.min  = '0;
                    n.hour = (t.hour == HOUR_W'(HOUR_MAX)) ? '0 : t.hour + 1'b1;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Clock divider producing a one-cycle tick every DIV enabled cycles.
// Holds its count while disabled; i_clr zeroes the count and suppresses the tick.
module stopwatch_tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = i_en && (r_cnt == TERM);
    assign o_tick = w_wrap && !i_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || w_wrap) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_dp.sv
// Stopwatch datapath: centisecond divider, cascaded live time counter and lap register.
// Lap register, save and restore exist only when STOPWATCH_DP_LAP_EN is defined.
module stopwatch_dp
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned TICK_HZ  = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_runstop,
    input  logic              i_clear,
    input  logic              i_save,
    input  logic              i_restore,
    output logic [CSEC_W-1:0] o_csec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic [CSEC_W-1:0] o_lap_csec,
    output logic [SEC_W-1:0]  o_lap_sec,
    output logic [MIN_W-1:0]  o_lap_min,
    output logic [HOUR_W-1:0] o_lap_hour,
    output logic              o_tick
);

    localparam int unsigned DIV = CLK_FREQ / TICK_HZ;

    time_t r_live;
    time_t w_lap;
    logic  r_tick;
    logic  w_tick;
    logic  w_restore;

`ifdef STOPWATCH_DP_LAP_EN
    time_t r_lap;
    logic  w_save;

    assign w_restore = i_restore && !i_clear;
    assign w_save    = i_save && !i_clear && !i_restore;
    assign w_lap     = r_lap;

    // Captures the pre-increment live value even when a tick lands in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lap <= '0;
        end else if (w_save) begin
            r_lap <= r_live;
        end
    end
`else
    logic w_unused;

    assign w_unused  = i_save ^ i_restore;
    assign w_restore = 1'b0;
    assign w_lap     = '0;
`endif

    stopwatch_tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .i_en  (i_runstop),
        .i_clr (i_clear || w_restore),
        .o_tick(w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tick;
            if (i_clear) begin
                r_live <= '0;
            end else if (w_restore) begin
                r_live <= w_lap;
            end else if (w_tick) begin
                r_live <= time_inc(r_live);
            end
        end
    end

    assign o_csec     = r_live.csec;
    assign o_sec      = r_live.sec;
    assign o_min      = r_live.min;
    assign o_hour     = r_live.hour;
    assign o_lap_csec = w_lap.csec;
    assign o_lap_sec  = w_lap.sec;
    assign o_lap_min  = w_lap.min;
    assign o_lap_hour = w_lap.hour;
    assign o_tick     = r_tick;

endmodule

// File: doc/stopwatch_dp.md
Name: stopwatch_dp

Overview:
- Stopwatch datapath; sits directly downstream of the stopwatch control unit and consumes its four registered control outputs.
- Divides the system clock to a centisecond tick and runs a cascaded time counter: csec 0-99, sec 0-59, min 0-59, hour 0-23.
- Holds one lap (snapshot) register for save/restore.
- Feeds the FND/display mux with live and lap time.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz (centisecond). Divider terminal count DIV = CLK_FREQ/TICK_HZ; DIV must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- i_runstop  in  1  level; 1 = count enabled
- i_clear  in  1  pulse/level; zero live time
- i_save  in  1  pulse/level; snapshot live time into lap register
- i_restore  in  1  pulse/level; load lap register into live time
- o_csec  out  7  live centiseconds 0-99
- o_sec  out  6  live seconds 0-59
- o_min  out  6  live minutes 0-59
- o_hour  out  5  live hours 0-23
- o_lap_csec/o_lap_sec/o_lap_min/o_lap_hour  out  7/6/6/5  lap register fields
- o_tick  out  1  one-cycle pulse on every centisecond increment

Behaviour:
- Reset: all live fields 0, all lap fields 0, divider 0, o_tick 0.
- Divider:
  - Counts 0..DIV-1 only while i_runstop=1. Holds its value while i_runstop=0, so pause and resume keep the fractional period.
  - On reaching DIV-1 it wraps to 0 and asserts the internal tick for that cycle.
- Outputs: registered. Live fields update on the clock edge ending the tick cycle, and o_tick is high in the same cycle the new value appears (1-cycle latency from divider wrap).
- Cascade on tick:
  - csec increments.
  - csec 99 wraps to 0 and carries to sec; sec 59 wraps to 0 and carries to min; min 59 wraps to 0 and carries to hour.
  - hour 23 with a full carry wraps to 0, so 23:59:59.99 goes to 00:00:00.00.
- Per-cycle priority (highest first):
  1. i_clear: live fields and divider go to 0. Lap register is untouched.
  2. i_restore: live fields are loaded from the lap register and the divider goes to 0.
  3. i_save: lap register is loaded from the current live fields (the pre-increment value if a tick happens in the same cycle). The tick still applies to the live fields.
  4. Tick increment.
- Control inputs act on level each cycle. A repeated clear, save or restore is idempotent.
- i_runstop=0 blocks ticks only; clear, save and restore still act while stopped.
- No tick is generated in a cycle where clear or restore wins, and o_tick stays 0 that cycle.
- Asserting rst mid-count returns every register to its reset value immediately (asynchronous). The first tick after release occurs DIV cycles after i_runstop=1.

Optional Feature:
- Macro STOPWATCH_DP_LAP_EN.
- Defined: lap register, save and restore behave as above.
- Undefined:
  - Lap register is not built; o_lap_* are tied to 0.
  - i_save and i_restore are ignored.
  - Priority reduces to clear, then tick.
- Port list is identical in both builds.

Decomposition:
- Shared package stopwatch_pkg:
  - Field width constants CSEC_W=7, SEC_W=6, MIN_W=6, HOUR_W=5.
  - Max constants CSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Packed time-struct typedef (hour, min, sec, csec), used for live and lap values.
- One sub-module, stopwatch_tick_gen: parameterised divider with enable and synchronous clear inputs, and a tick output.
- The cascade counter and lap register stay in stopwatch_dp.

Test Plan (bench uses CLK_FREQ=100, TICK_HZ=10, so DIV=10):
- Reset, then i_runstop=1 for 1000 cycles -> csec=100 mod 100 rollover: sec=1, csec=0; o_tick pulses exactly 100 times, every 10 cycles.
- Preload 23:59:59.99 via save+restore, then run one tick -> 00:00:00.00 with o_tick=1.
- Run 7 cycles, drop i_runstop for 50 cycles, raise it again -> next tick occurs exactly 3 cycles after resume; csec unchanged during pause.
- At 00:00:01.25, i_save while ticking -> lap=00:00:01.25 and live=00:00:01.26. Then i_clear -> live=0, lap still 01.25. Then i_restore -> live=00:00:01.25.
- i_clear and i_restore asserted in the same cycle -> live=0 (clear wins).
- Assert rst at a random mid-count point -> all outputs 0 in the same cycle, without a clock edge.
- Build without STOPWATCH_DP_LAP_EN, pulse i_save then i_restore -> o_lap_* stay 0 and live time is unaffected.
